// File: rtl/fu_writeback_unit.sv
// rtl/fu_writeback_unit.sv - three-FU execute/hold stage with round-robin single-bus writeback
module fu_writeback_unit #(
    parameter int AR_SIZE  = 7,
    parameter int FU_ARRAY = 3,
    parameter int MUL_LAT  = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [FU_ARRAY-1:0] issue_valid_in,
    input  logic [AR_SIZE-1:0]  rd_in0,
    input  logic [AR_SIZE-1:0]  rd_in1,
    input  logic [AR_SIZE-1:0]  rd_in2,
    input  logic [31:0]         rs1_value_in0,
    input  logic [31:0]         rs1_value_in1,
    input  logic [31:0]         rs1_value_in2,
    input  logic [31:0]         rs2_value_in0,
    input  logic [31:0]         rs2_value_in1,
    input  logic [31:0]         rs2_value_in2,
    input  logic [31:0]         imm_value_in0,
    input  logic [31:0]         imm_value_in1,
    input  logic [31:0]         imm_value_in2,
    input  logic [2:0]          op_in0,
    input  logic [2:0]          op_in2,
    output logic [FU_ARRAY-1:0] fu_ready_out,
    output logic                wb_valid_out,
    output logic [AR_SIZE-1:0]  reg_tag_out,
    output logic [31:0]         reg_value_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } fu_state_t;

    fu_state_t          r_state     [FU_ARRAY];
    fu_state_t          w_state_nxt [FU_ARRAY];
    logic [31:0]        r_result    [FU_ARRAY];
    logic [AR_SIZE-1:0] r_tag       [FU_ARRAY];
    logic [3:0]         r_cnt;
    logic [1:0]         r_rr_ptr;

    logic [AR_SIZE-1:0] w_rd        [FU_ARRAY];
    logic [31:0]        w_res_in    [FU_ARRAY];
    logic [FU_ARRAY-1:0] w_issue_ok;
    logic [FU_ARRAY-1:0] w_req;
    logic               w_grant_valid;
    logic [1:0]         w_grant_idx;
    logic [2:0]         w_sum;
    logic [1:0]         w_cand;
    logic [31:0]        w_alu0;
    logic [31:0]        w_alu2;
    logic [31:0]        w_mul;
    logic               w_unused;

    function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a + imm;
            default: return a | imm;
        endcase
    endfunction

    // FU1 has no immediate operand
    assign w_unused = ^imm_value_in1;

    assign w_alu0 = alu_calc(op_in0, rs1_value_in0, rs2_value_in0, imm_value_in0);
    assign w_alu2 = alu_calc(op_in2, rs1_value_in2, rs2_value_in2, imm_value_in2);
    // product is captured at issue; the EXEC countdown only models multiplier latency
    assign w_mul  = rs1_value_in1 * rs2_value_in1;

    assign w_rd[0]     = rd_in0;
    assign w_rd[1]     = rd_in1;
    assign w_rd[2]     = rd_in2;
    assign w_res_in[0] = w_alu0;
    assign w_res_in[1] = w_mul;
    assign w_res_in[2] = w_alu2;

    // ready flags, accepted issues and writeback requests from registered state
    always_comb begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            fu_ready_out[i] = (r_state[i] == ST_IDLE);
            w_issue_ok[i]   = issue_valid_in[i] && (r_state[i] == ST_IDLE);
            w_req[i]        = (r_state[i] == ST_HOLD);
        end
    end

    // round-robin pick starting at r_rr_ptr
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 2'd0;
        w_sum         = 3'd0;
        w_cand        = 2'd0;
        for (int k = 0; k < FU_ARRAY; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + 3'(k);
            w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_grant_valid && w_req[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // per-FU next state; rd=0 results drop straight back to IDLE
    always_comb begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (issue_valid_in[i]) begin
                        if (i == 1)
                            w_state_nxt[i] = ST_EXEC;
                        else if (w_rd[i] != '0)
                            w_state_nxt[i] = ST_HOLD;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt <= 4'd1)
                        w_state_nxt[i] = (r_tag[i] != '0) ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (w_grant_valid && (w_grant_idx == 2'(i)))
                        w_state_nxt[i] = ST_IDLE;
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FU_ARRAY; i++)
                r_state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < FU_ARRAY; i++)
                r_state[i] <= w_state_nxt[i];
        end
    end

    // result capture, multiplier countdown, arbiter pointer and registered broadcast
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                r_result[i] <= '0;
                r_tag[i]    <= '0;
            end
            r_cnt         <= 4'd0;
            r_rr_ptr      <= 2'd0;
            wb_valid_out  <= 1'b0;
            reg_tag_out   <= '0;
            reg_value_out <= '0;
        end else begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                if (w_issue_ok[i]) begin
                    r_result[i] <= w_res_in[i];
                    r_tag[i]    <= w_rd[i];
                end
            end
            if (w_issue_ok[1])
                r_cnt <= 4'(MUL_LAT);
            else if ((r_state[1] == ST_EXEC) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            if (w_grant_valid) begin
                wb_valid_out  <= 1'b1;
                reg_tag_out   <= r_tag[w_grant_idx];
                reg_value_out <= r_result[w_grant_idx];
                r_rr_ptr      <= (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
            end else begin
                wb_valid_out  <= 1'b0;
                reg_tag_out   <= '0;
                reg_value_out <= '0;
            end
        end
    end

endmodule
